// File: rtl/chan_mux_rr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chan_mux_rr_if : producer/consumer bus for the N:1 handshake mux     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface chan_mux_rr_if #(
   parameter int WIDTH = 4,
   parameter int NCH   = 4
);
   localparam int SELW = $clog2(NCH);

   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [WIDTH-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [SELW-1:0]      out_chan;

   // master: the environment side (producers, consumer, control)
   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_chan
   );

   // slave: the mux itself
   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_chan
   );
endinterface
`default_nettype wire

// File: rtl/chan_mux_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chan_mux_rr : registered N:1 valid/ready mux, fixed or round-robin   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module chan_mux_rr #(
   parameter int WIDTH = 4,
   parameter int NCH   = 4
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   chan_mux_rr_if.slave bus
);
   localparam int SELW = $clog2(NCH);

   logic [1:0]       r_rst_sync;
   logic [SELW-1:0]  r_ptr;
   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_chan;
   logic             r_out_valid;

   logic             w_rst_ok;
   logic             w_load_en;
   logic [SELW-1:0]  w_pick;
   logic             w_pick_ok;
   logic [WIDTH-1:0] w_pick_data;
   logic             w_take;

   // Reset asserts asynchronously but releases two edges later, synchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_ok  = r_rst_sync[1];
   assign w_load_en = !r_out_valid || bus.out_ready;

   // Round-robin search runs from ptr+NCH down to ptr+1 so the nearest
   // valid channel after ptr is the last (winning) assignment.
   always_comb begin
      int idx;
      idx       = 0;
      w_pick    = '0;
      w_pick_ok = 1'b0;
      if (bus.mode) begin
         for (int k = NCH; k >= 1; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (bus.in_valid[idx[SELW-1:0]]) begin
               w_pick    = idx[SELW-1:0];
               w_pick_ok = 1'b1;
            end
         end
      end else begin
         w_pick = bus.sel;
         for (int i = 0; i < NCH; i++) begin
            if ((int'(bus.sel) == i) && bus.in_valid[i]) w_pick_ok = 1'b1;
         end
      end
   end

   always_comb begin
      w_pick_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_pick == SELW'(i)) w_pick_data = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_ready
         assign bus.in_ready[i] = w_rst_ok && w_load_en && w_pick_ok && (w_pick == SELW'(i));
      end
   endgenerate

   assign w_take = |(bus.in_ready & bus.in_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_chan  <= '0;
         r_ptr       <= SELW'(NCH - 1);
      end else if (w_take) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_pick_data;
         r_out_chan  <= w_pick;
         if (bus.mode) r_ptr <= w_pick;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.out_data  = r_out_data;
   assign bus.out_chan  = r_out_chan;
   assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_chan_mux_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_chan_mux_rr : directed self-checking bench for chan_mux_rr        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_chan_mux_rr;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   chan_mux_rr_if #(.WIDTH(4), .NCH(4)) bus_a ();
   chan_mux_rr_if #(.WIDTH(4), .NCH(3)) bus_b ();

   chan_mux_rr #(.WIDTH(4), .NCH(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   chan_mux_rr #(.WIDTH(4), .NCH(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for the reset synchroniser to open the mux, bounded.
   task automatic wait_ready_a();
      int n;
      n = 0;
      while (bus_a.in_ready == 4'b0000 && n < 10) begin
         tick();
         n++;
      end
      check("ready_after_reset_timeout", 32'(n < 10), 32'd1);
   endtask

   initial begin
      int rr_exp [8];
      int skip_exp [4];
      rr_exp   = '{0, 1, 2, 3, 0, 1, 2, 3};
      skip_exp = '{0, 2, 3, 0};

      rst_n           = 1'b0;
      bus_a.in_data   = 16'hDCBA;
      bus_a.in_valid  = 4'hF;
      bus_a.mode      = 1'b1;
      bus_a.sel       = 2'd0;
      bus_a.out_ready = 1'b1;
      bus_b.in_data   = 12'h321;
      bus_b.in_valid  = 3'b000;
      bus_b.mode      = 1'b0;
      bus_b.sel       = 2'd0;
      bus_b.out_ready = 1'b1;

      // Reset state with every channel valid
      repeat (3) tick();
      check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
      check("rst_out_data",  32'(bus_a.out_data),  32'd0);
      check("rst_out_chan",  32'(bus_a.out_chan),  32'd0);
      check("rst_in_ready",  32'(bus_a.in_ready),  32'd0);

      rst_n = 1'b1;
      wait_ready_a();
      check("first_grant_ready", 32'(bus_a.in_ready), 32'b0001);

      // Round-robin fairness over 8 grants
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rr_valid", 32'(bus_a.out_valid), 32'd1);
         check("rr_chan",  32'(bus_a.out_chan),  32'(rr_exp[i]));
      end
      check("rr_data_last", 32'(bus_a.out_data), 32'hD);

      // Channel 1 drops out and is skipped
      bus_a.in_valid = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_skip_chan", 32'(bus_a.out_chan), 32'(skip_exp[i]));
      end

      // Fixed mode, sel = 2
      bus_a.mode     = 1'b0;
      bus_a.in_valid = 4'hF;
      bus_a.sel      = 2'd2;
      #1;
      check("fix_ready_sel2", 32'(bus_a.in_ready), 32'b0100);
      tick();
      check("fix_data_sel2", 32'(bus_a.out_data), 32'hC);
      check("fix_chan_sel2", 32'(bus_a.out_chan), 32'd2);

      // Sweep sel 0..3
      for (int s = 0; s < 4; s++) begin
         bus_a.sel = 2'(s);
         tick();
         check("sweep_data", 32'(bus_a.out_data), 32'(4'hA + s));
         check("sweep_chan", 32'(bus_a.out_chan), 32'(s));
      end

      // Backpressure after a load of 0xB from channel 1
      bus_a.sel = 2'd1;
      tick();
      check("bp_load_data", 32'(bus_a.out_data), 32'hB);
      bus_a.out_ready = 1'b0;
      bus_a.sel       = 2'd2;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", 32'(bus_a.in_ready), 32'd0);
         tick();
         check("bp_data",  32'(bus_a.out_data),  32'hB);
         check("bp_chan",  32'(bus_a.out_chan),  32'd1);
         check("bp_valid", 32'(bus_a.out_valid), 32'd1);
      end
      bus_a.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(bus_a.in_ready), 32'b0100);
      tick();
      check("bp_release_data",  32'(bus_a.out_data),  32'hC);
      check("bp_release_valid", 32'(bus_a.out_valid), 32'd1);

      // Drain with nothing valid
      bus_a.in_valid = 4'b0000;
      tick();
      check("drain_valid", 32'(bus_a.out_valid), 32'd0);
      check("drain_data_hold", 32'(bus_a.out_data), 32'hC);

      // Back to round-robin: ptr was last set to 0 by the RR phase, not by fixed mode
      bus_a.mode     = 1'b1;
      bus_a.in_valid = 4'hF;
      tick();
      check("ptr_kept_chan", 32'(bus_a.out_chan), 32'd1);
      check("ptr_kept_data", 32'(bus_a.out_data), 32'hB);

      // Reset while the word is stalled
      bus_a.out_ready = 1'b0;
      tick();
      check("stall_valid", 32'(bus_a.out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(bus_a.out_valid), 32'd0);
      check("midrst_ready", 32'(bus_a.in_ready),  32'd0);
      tick();
      rst_n           = 1'b1;
      bus_a.out_ready = 1'b1;
      wait_ready_a();
      check("midrst_first_ready", 32'(bus_a.in_ready), 32'b0001);
      tick();
      check("midrst_first_chan", 32'(bus_a.out_chan), 32'd0);

      // NCH = 3: an out-of-range sel selects nothing
      bus_b.in_valid = 3'b111;
      bus_b.sel      = 2'd0;
      tick();
      check("n3_load_valid", 32'(bus_b.out_valid), 32'd1);
      check("n3_load_data",  32'(bus_b.out_data),  32'h1);
      bus_b.sel = 2'd3;
      #1;
      check("n3_sel3_ready", 32'(bus_b.in_ready), 32'd0);
      tick();
      check("n3_sel3_valid", 32'(bus_b.out_valid), 32'd0);
      check("n3_sel3_data_hold", 32'(bus_b.out_data), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
